// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared RAM geometry, command type and helpers for the RAM arbiter
//
// Used by ram_arbiter_if, ram_read_tracker and ram_arbiter.
//   RAM_ADDR_WIDTH : word address width of the RAM
//   RAM_DATA_WIDTH : data width of one RAM word
//   RAM_BYTE_COUNT : number of byte lanes (byte enables) per word
//   port_id_t      : requester index (0 or 1)
//   ram_cmd_t      : one cycle of RAM-side command signals
package ram_pkg;

    localparam int RAM_ADDR_WIDTH = 14;
    localparam int RAM_DATA_WIDTH = 64;
    localparam int RAM_BYTE_COUNT = 8;

    typedef logic port_id_t;

    typedef struct packed {
        logic [RAM_ADDR_WIDTH-1:0] address;
        logic [RAM_BYTE_COUNT-1:0] byteena;
        logic [RAM_DATA_WIDTH-1:0] data;
        logic                      wren;
    } ram_cmd_t;

    // Command driven onto the RAM when nothing is granted: everything low.
    function automatic ram_cmd_t ram_idle_cmd();
        return '0;
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - one requester port of the RAM arbiter
//
// Signals:
//   req         : request valid (requester -> arbiter)
//   addr        : word address
//   byteena     : write byte enables
//   wdata       : write data
//   we          : 1 = write, 0 = read
//   ready       : request accepted this cycle (arbiter -> requester)
//   rdata       : read data
//   rdata_valid : rdata carries this port's read result this cycle
// Modports: master (requester side), slave (arbiter side).
interface ram_arbiter_if;
    import ram_pkg::*;

    logic                      req;
    logic [RAM_ADDR_WIDTH-1:0] addr;
    logic [RAM_BYTE_COUNT-1:0] byteena;
    logic [RAM_DATA_WIDTH-1:0] wdata;
    logic                      we;
    logic                      ready;
    logic [RAM_DATA_WIDTH-1:0] rdata;
    logic                      rdata_valid;

    modport master (
        output req, addr, byteena, wdata, we,
        input  ready, rdata, rdata_valid
    );

    modport slave (
        input  req, addr, byteena, wdata, we,
        output ready, rdata, rdata_valid
    );

endinterface

// File: rtl/ram_read_tracker.sv
// rtl/ram_read_tracker.sv - return-tag shift register matching RAM read latency
//
// Parameters:
//   READ_LATENCY : cycles from accepted read to valid RAM q (>= 1)
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset (clears all tags)
//   push         : an accepted read enters this cycle
//   push_port    : port that issued the read
//   valid        : a tracked read's data is on RAM q this cycle
//   port         : port the returning data belongs to
module ram_read_tracker
    import ram_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     push,
    input  port_id_t push_port,
    output logic     valid,
    output port_id_t port
);

    logic     vld_sr [READ_LATENCY];
    port_id_t id_sr  [READ_LATENCY];

    // Stage 0 holds a read accepted last cycle, so the last stage lines up
    // exactly READ_LATENCY cycles after acceptance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                vld_sr[i] <= 1'b0;
                id_sr[i]  <= 1'b0;
            end
        end else begin
            vld_sr[0] <= push;
            id_sr[0]  <= push_port;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_sr[i] <= vld_sr[i-1];
                id_sr[i]  <= id_sr[i-1];
            end
        end
    end

    assign valid = vld_sr[READ_LATENCY-1];
    assign port  = id_sr[READ_LATENCY-1];

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-port arbiter in front of a single-port RAM
//
// Build option: RAM_ARBITER_ROUND_ROBIN_EN
//   defined   : simultaneous requests alternate, favouring the port not granted last
//   undefined : simultaneous requests always go to port 0
// Parameters:
//   READ_LATENCY : cycles from accepted read to valid ram_q
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   p0, p1       : requester ports (ram_arbiter_if.slave)
//   ram_address, ram_byteena, ram_data, ram_wren : RAM command outputs
//   ram_q        : RAM read data
module ram_arbiter
    import ram_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    ram_arbiter_if.slave              p0,
    ram_arbiter_if.slave              p1,
    output logic [RAM_ADDR_WIDTH-1:0] ram_address,
    output logic [RAM_BYTE_COUNT-1:0] ram_byteena,
    output logic [RAM_DATA_WIDTH-1:0] ram_data,
    output logic                      ram_wren,
    input  logic [RAM_DATA_WIDTH-1:0] ram_q
);

    logic     gnt_valid;
    port_id_t gnt_port;
    port_id_t contested_winner;
    ram_cmd_t cmd;
    logic     trk_valid;
    port_id_t trk_port;

`ifdef RAM_ARBITER_ROUND_ROBIN_EN
    port_id_t last_grant;

    // Reset to 1 so port 0 wins the first contested cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
        end else if (gnt_valid) begin
            last_grant <= gnt_port;
        end
    end

    assign contested_winner = ~last_grant;
`else
    assign contested_winner = 1'b0;
`endif

    // Grant is purely combinational so ready rises in the request cycle.
    // Nothing is accepted while reset is asserted.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_port  = 1'b0;
        if (reset_n) begin
            if (p0.req && p1.req) begin
                gnt_valid = 1'b1;
                gnt_port  = contested_winner;
            end else if (p0.req) begin
                gnt_valid = 1'b1;
                gnt_port  = 1'b0;
            end else if (p1.req) begin
                gnt_valid = 1'b1;
                gnt_port  = 1'b1;
            end
        end
    end

    assign p0.ready = gnt_valid && (gnt_port == 1'b0);
    assign p1.ready = gnt_valid && (gnt_port == 1'b1);

    // Reads always enable every byte lane; idle drives the RAM to all zeros.
    always_comb begin
        cmd = ram_idle_cmd();
        if (gnt_valid) begin
            if (gnt_port) begin
                cmd.address = p1.addr;
                cmd.byteena = p1.we ? p1.byteena : '1;
                cmd.data    = p1.wdata;
                cmd.wren    = p1.we;
            end else begin
                cmd.address = p0.addr;
                cmd.byteena = p0.we ? p0.byteena : '1;
                cmd.data    = p0.wdata;
                cmd.wren    = p0.we;
            end
        end
    end

    assign ram_address = cmd.address;
    assign ram_byteena = cmd.byteena;
    assign ram_data    = cmd.data;
    assign ram_wren    = cmd.wren;

    ram_read_tracker #(
        .READ_LATENCY (READ_LATENCY)
    ) u_tracker (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (gnt_valid && !cmd.wren),
        .push_port (gnt_port),
        .valid     (trk_valid),
        .port      (trk_port)
    );

    // Both ports see ram_q; only the tagged owner gets the valid strobe.
    assign p0.rdata       = ram_q;
    assign p1.rdata       = ram_q;
    assign p0.rdata_valid = trk_valid && (trk_port == 1'b0);
    assign p1.rdata_valid = trk_valid && (trk_port == 1'b1);

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - scoreboard bench for ram_arbiter at READ_LATENCY 1 and 2
module tb_ram_arbiter;
    import ram_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [1:0]  req, we;
    logic [13:0] addr [2];
    logic [7:0]  be   [2];
    logic [63:0] wd   [2];

    logic [1:0]  dut_ready [2];
    logic [1:0]  dut_valid [2];
    logic [63:0] dut_rdata [2][2];
    logic [13:0] dut_addr  [2];
    logic [7:0]  dut_be    [2];
    logic [63:0] dut_data  [2];
    logic        dut_wren  [2];

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int model_last = 1;
    logic [1:0] acc = 2'b00;

    typedef struct {
        int          due;
        logic [63:0] data;
    } exp_t;
    exp_t sbq [2][2][$];

    logic [63:0] ref_mem [int];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] init_word(int a);
        logic [31:0] x;
        x = a;
        if (a == 16) return 64'h1122334455667788;
        return {x ^ 32'hA5A50000, x * 32'h9E3779B1};
    endfunction

    function automatic logic [63:0] merge(logic [63:0] old, logic [63:0] nw, logic [7:0] b);
        logic [63:0] r;
        r = old;
        for (int i = 0; i < 8; i++) if (b[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    function automatic logic [63:0] ref_rd(int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    task automatic chk(string name, int k, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, k, cyc, act, exp);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g
        ram_arbiter_if p0_if ();
        ram_arbiter_if p1_if ();
        logic [13:0] ram_address;
        logic [7:0]  ram_byteena;
        logic [63:0] ram_data;
        logic        ram_wren;
        logic [63:0] ram_q;
        logic [63:0] mem [int];
        logic [63:0] qp [k+1];

        assign p0_if.req = req[0];  assign p1_if.req = req[1];
        assign p0_if.we  = we[0];   assign p1_if.we  = we[1];
        assign p0_if.addr = addr[0];  assign p1_if.addr = addr[1];
        assign p0_if.byteena = be[0]; assign p1_if.byteena = be[1];
        assign p0_if.wdata = wd[0];   assign p1_if.wdata = wd[1];

        ram_arbiter #(.READ_LATENCY(k + 1)) dut (
            .clk         (clk),
            .reset_n     (reset_n),
            .p0          (p0_if.slave),
            .p1          (p1_if.slave),
            .ram_address (ram_address),
            .ram_byteena (ram_byteena),
            .ram_data    (ram_data),
            .ram_wren    (ram_wren),
            .ram_q       (ram_q)
        );

        // Behavioural single-port RAM with k+1 cycles of read latency.
        always @(posedge clk) begin
            qp[0] <= mem.exists(int'(ram_address)) ? mem[int'(ram_address)] : init_word(int'(ram_address));
            for (int i = 1; i <= k; i++) qp[i] <= qp[i-1];
            if (ram_wren)
                mem[int'(ram_address)] = merge(mem.exists(int'(ram_address)) ? mem[int'(ram_address)]
                                               : init_word(int'(ram_address)), ram_data, ram_byteena);
        end
        assign ram_q = qp[k];

        assign dut_ready[k] = {p1_if.ready, p0_if.ready};
        assign dut_valid[k] = {p1_if.rdata_valid, p0_if.rdata_valid};
        assign dut_rdata[k][0] = p0_if.rdata;
        assign dut_rdata[k][1] = p1_if.rdata;
        assign dut_addr[k] = ram_address;
        assign dut_be[k]   = ram_byteena;
        assign dut_data[k] = ram_data;
        assign dut_wren[k] = ram_wren;
    end

    // Reference model: decides the grant from the arbitration rules, checks the
    // request-side and RAM-side outputs, and queues expected read returns.
    always @(negedge clk) begin : model
        int g;
        logic [1:0] exp_rdy;
        g = -1;
        if (reset_n) begin
            if (req[0] && req[1]) begin
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
                g = (model_last == 0) ? 1 : 0;
`else
                g = 0;
`endif
            end else if (req[0]) g = 0;
            else if (req[1]) g = 1;
        end else begin
            model_last = 1;
        end
        acc = 2'b00;
        exp_rdy = (g < 0) ? 2'b00 : (g == 0 ? 2'b01 : 2'b10);
        for (int k = 0; k < 2; k++) begin
            chk("ready", k, 64'(dut_ready[k]), 64'(exp_rdy));
            if (g < 0) begin
                chk("idle_wren", k, 64'(dut_wren[k]), 64'd0);
                chk("idle_addr", k, 64'(dut_addr[k]), 64'd0);
                chk("idle_be",   k, 64'(dut_be[k]),   64'd0);
                chk("idle_data", k, dut_data[k],      64'd0);
            end else begin
                chk("ram_wren", k, 64'(dut_wren[k]), 64'(we[g]));
                chk("ram_addr", k, 64'(dut_addr[k]), 64'(addr[g]));
                chk("ram_be",   k, 64'(dut_be[k]),   64'(we[g] ? be[g] : 8'hFF));
                chk("ram_data", k, dut_data[k],      wd[g]);
            end
        end
        if (g >= 0) begin
            acc[g] = 1'b1;
            model_last = g;
            if (we[g]) ref_mem[int'(addr[g])] = merge(ref_rd(int'(addr[g])), wd[g], be[g]);
            else for (int k = 0; k < 2; k++) sbq[k][g].push_back('{due: cyc + k + 1, data: ref_rd(int'(addr[g]))});
        end
    end

    // Monitor: every cycle, each port's valid must match whether a return is due.
    always @(negedge clk) begin : monitor
        logic expv;
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 2; p++) begin
                if (!reset_n) sbq[k][p].delete();
                expv = (sbq[k][p].size() > 0) && (sbq[k][p][0].due == cyc);
                chk(p == 0 ? "p0_rdata_valid" : "p1_rdata_valid", k, 64'(dut_valid[k][p]), 64'(expv));
                if (expv) begin
                    if (dut_valid[k][p]) chk(p == 0 ? "p0_rdata" : "p1_rdata", k, dut_rdata[k][p], sbq[k][p][0].data);
                    void'(sbq[k][p].pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(int p, bit r, bit w, logic [13:0] a, logic [7:0] b, logic [63:0] d);
        req[p] = r; we[p] = w; addr[p] = a; be[p] = b; wd[p] = d;
    endtask

    task automatic idle_all();
        set_port(0, 0, 0, 14'h0, 8'h0, 64'h0);
        set_port(1, 0, 0, 14'h0, 8'h0, 64'h0);
    endtask

    initial begin
        reset_n = 1'b0;
        idle_all();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // No requests for ten cycles.
        repeat (10) step();

        // Both ports request continuously for six cycles.
        set_port(0, 1, 0, 14'h0005, 8'h00, 64'h0);
        set_port(1, 1, 0, 14'h0006, 8'h00, 64'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
                chk("contested_seq", k, 64'(dut_ready[k]), (i % 2 == 0) ? 64'd1 : 64'd2);
`else
                chk("contested_seq", k, 64'(dut_ready[k]), 64'd1);
`endif
            end
            step();
        end
        idle_all();
        repeat (3) step();

        // Port 0 read of 0x0010 alone.
        set_port(0, 1, 0, 14'h0010, 8'h00, 64'h0);
        step();
        idle_all();
        repeat (3) step();

        // Port 1 partial write to the top address, then read it back.
        set_port(1, 1, 1, 14'h3FFF, 8'h0F, 64'hAABBCCDD00112233);
        step();
        idle_all();
        repeat (3) step();
        set_port(0, 1, 0, 14'h3FFF, 8'h00, 64'h0);
        step();
        idle_all();
        repeat (3) step();

        // Alternating single-port reads for four cycles.
        for (int i = 0; i < 4; i++) begin
            idle_all();
            set_port(i % 2, 1, 0, 14'(i + 32), 8'h00, 64'h0);
            step();
        end
        idle_all();
        repeat (4) step();

        // Reset with a read in flight, then a contested request.
        set_port(0, 1, 0, 14'h0010, 8'h00, 64'h0);
        step();
        reset_n = 1'b0;
        idle_all();
        step();
        reset_n = 1'b1;
        repeat (4) step();
        set_port(0, 1, 0, 14'h0001, 8'h00, 64'h0);
        set_port(1, 1, 0, 14'h0002, 8'h00, 64'h0);
        @(negedge clk);
        for (int k = 0; k < 2; k++) chk("post_reset_grant", k, 64'(dut_ready[k]), 64'd1);
        step();
        idle_all();
        repeat (3) step();

        // Random traffic; a rejected request is held unchanged until accepted.
        for (int n = 0; n < 3000; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!(req[p] && !acc[p])) begin
                    req[p]  = ($urandom_range(0, 9) < 6);
                    we[p]   = $urandom_range(0, 1) == 1;
                    addr[p] = ($urandom_range(0, 7) == 0) ? 14'h3FFF : 14'($urandom_range(0, 15));
                    be[p]   = 8'($urandom);
                    wd[p]   = {$urandom, $urandom};
                end
            end
            step();
        end
        idle_all();
        repeat (6) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
